// File: rtl/i2c_slave_core.sv
// Byte-level I2C slave with 7-bit addressing, oversampled on clk.
// Ports: clk/reset, scl/sda bus, data_out+data_ready+start (rx), data_in (tx), ack_error.
module i2c_slave_core #(
  parameter logic [6:0] SLAVE_ADDR = 7'h6A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] data_out,
  input  logic [7:0] data_in,
  output logic       data_ready,
  output logic       start,
  output logic       ack_error
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK
  } state_t;

  state_t     state_q;
  logic       scl_m_q, scl_s_q, scl_h_q;
  logic       sda_m_q, sda_s_q, sda_h_q;
  logic [3:0] cnt_q;
  logic [6:0] sh_q;
  logic [6:0] tx_q;
  logic       rw_q;
  logic       first_q;
  logic       ack_on_q;
  logic       oe_q;
  logic [7:0] data_out_q;
  logic       data_ready_q, start_q, ack_error_q;

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_s_q & ~scl_h_q;
  assign scl_fall  = ~scl_s_q & scl_h_q;
  // bus conditions only count while scl is high and stable
  assign start_det = scl_s_q & scl_h_q & ~sda_s_q & sda_h_q;
  assign stop_det  = scl_s_q & scl_h_q & sda_s_q & ~sda_h_q;

  assign sda        = oe_q ? 1'b0 : 1'bz;
  assign data_out   = data_out_q;
  assign data_ready = data_ready_q;
  assign start      = start_q;
  assign ack_error  = ack_error_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      scl_m_q      <= 1'b1;
      scl_s_q      <= 1'b1;
      scl_h_q      <= 1'b1;
      sda_m_q      <= 1'b1;
      sda_s_q      <= 1'b1;
      sda_h_q      <= 1'b1;
      cnt_q        <= '0;
      sh_q         <= '0;
      tx_q         <= '0;
      rw_q         <= 1'b0;
      first_q      <= 1'b0;
      ack_on_q     <= 1'b0;
      oe_q         <= 1'b0;
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
      start_q      <= 1'b0;
      ack_error_q  <= 1'b0;
    end else begin
      scl_m_q      <= scl;
      scl_s_q      <= scl_m_q;
      scl_h_q      <= scl_s_q;
      sda_m_q      <= sda;
      sda_s_q      <= sda_m_q;
      sda_h_q      <= sda_s_q;
      data_ready_q <= 1'b0;
      start_q      <= 1'b0;
      ack_error_q  <= 1'b0;
      if (start_det) begin
        state_q  <= ADDR;
        cnt_q    <= '0;
        oe_q     <= 1'b0;
        ack_on_q <= 1'b0;
      end else if (stop_det) begin
        state_q  <= IDLE;
        oe_q     <= 1'b0;
        ack_on_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise) begin
              sh_q  <= {sh_q[5:0], sda_s_q};
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                if (sh_q == SLAVE_ADDR) begin
                  state_q  <= ADDR_ACK;
                  rw_q     <= sda_s_q;
                  ack_on_q <= 1'b0;
                end else begin
                  state_q <= IDLE;
                end
              end
            end
          end
          // first fall drives ACK, second fall releases it
          ADDR_ACK, RX_ACK: begin
            if (scl_fall) begin
              if (!ack_on_q) begin
                oe_q     <= 1'b1;
                ack_on_q <= 1'b1;
              end else begin
                ack_on_q <= 1'b0;
                cnt_q    <= '0;
                if (state_q == ADDR_ACK && rw_q) begin
                  tx_q    <= data_in[6:0];
                  oe_q    <= ~data_in[7];
                  state_q <= TX;
                end else begin
                  oe_q    <= 1'b0;
                  state_q <= RX;
                  if (state_q == ADDR_ACK) first_q <= 1'b1;
                end
              end
            end
          end
          RX: begin
            if (scl_rise) begin
              sh_q  <= {sh_q[5:0], sda_s_q};
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                data_out_q   <= {sh_q, sda_s_q};
                data_ready_q <= 1'b1;
                start_q      <= first_q;
                first_q      <= 1'b0;
                ack_on_q     <= 1'b0;
                state_q      <= RX_ACK;
              end
            end
          end
          TX: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                oe_q     <= 1'b0;
                ack_on_q <= 1'b0;
                state_q  <= TX_ACK;
              end else begin
                oe_q <= ~tx_q[6];
                tx_q <= {tx_q[5:0], 1'b0};
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (sda_s_q) begin
                ack_error_q <= 1'b1;
                state_q     <= IDLE;
              end else begin
                ack_on_q <= 1'b1;
              end
            end else if (scl_fall && ack_on_q) begin
              ack_on_q <= 1'b0;
              cnt_q    <= '0;
              tx_q     <= data_in[6:0];
              oe_q     <= ~data_in[7];
              state_q  <= TX;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: bus-level master, transaction model,
// per-cycle compare process.
module tb_i2c_slave_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_sda;
  wire        sda;
  logic [7:0] data_out;
  logic [7:0] data_in;
  logic       data_ready, start, ack_error;

  pullup (sda);
  assign sda = m_sda ? 1'bz : 1'b0;

  i2c_slave_core dut (
    .clk        (clk),
    .reset      (reset),
    .scl        (scl),
    .sda        (sda),
    .data_out   (data_out),
    .data_in    (data_in),
    .data_ready (data_ready),
    .start      (start),
    .ack_error  (ack_error)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // transaction-level model
  logic [8:0] exp_q[$];
  logic [7:0] model_last = 8'h00;
  logic [7:0] rd_exp = 8'h00;
  bit         addr_phase = 0;
  bit         first = 0;
  int         mode = 0;
  int         ae_exp = 0;

  // monitor counters
  int  dr_seen = 0, st_seen = 0, ae_seen = 0, slave_low = 0;
  bit  mon_en = 0;
  logic [8:0] e;

  always @(negedge clk) begin
    if (reset && mon_en) begin
      if (data_ready) begin
        dr_seen++;
        if (start) st_seen++;
        check("strobe_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("data_out", data_out, e[7:0]);
          check("start_flag", start, e[8]);
          model_last = e[7:0];
        end
      end else begin
        check("data_hold", data_out, model_last);
        check("start_alone", start, 0);
      end
      if (ack_error) ae_seen++;
      if (m_sda && sda === 1'b0) slave_low++;
    end
  end

  // one scl period starting just after a fall: 100 low, 100 high
  task automatic clk_bit(input logic drv, output logic smp);
    #60 m_sda = drv;
    #40 scl = 1'b1;
    #50 smp = sda;
    #50 scl = 1'b0;
  endtask

  task automatic i2c_start();
    #60 m_sda = 1'b1;
    #40 scl = 1'b1;
    #100 m_sda = 1'b0;
    #100 scl = 1'b0;
    addr_phase = 1;
    mode = 0;
  endtask

  task automatic i2c_stop();
    #60 m_sda = 1'b0;
    #40 scl = 1'b1;
    #100 m_sda = 1'b1;
    #100;
    addr_phase = 0;
    mode = 0;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    logic exp_ack, smp;
    exp_ack = 1'b0;
    if (addr_phase) begin
      addr_phase = 0;
      exp_ack = (b[7:1] == 7'h6A);
      mode = exp_ack ? (b[0] ? 2 : 1) : 0;
      first = 1;
    end else if (mode == 1) begin
      exp_ack = 1'b1;
      exp_q.push_back({first, b});
      first = 0;
    end
    for (int i = 7; i >= 0; i--) begin
      clk_bit(b[i], smp);
      check("wr_bit", smp, b[i]);
    end
    clk_bit(1'b1, smp);
    check("ack", !smp, exp_ack);
  endtask

  task automatic rd_byte(input logic nack, input logic [7:0] nxt);
    logic [7:0] got;
    logic smp;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, smp);
      got[i] = smp;
    end
    check("rd_byte", got, rd_exp);
    #60 m_sda = nack;
    #40 scl = 1'b1;
    #50 data_in = nxt;
    #50 scl = 1'b0;
    if (nack) ae_exp++;
    else rd_exp = nxt;
  endtask

  int d0, s0, a0, l0;
  logic smp;
  logic [6:0] ra;

  initial begin
    reset = 1'b0;
    scl = 1'b1;
    m_sda = 1'b1;
    data_in = 8'h00;
    #55;
    check("rst_data_out", data_out, 0);
    check("rst_data_ready", data_ready, 0);
    check("rst_start", start, 0);
    check("rst_ack_error", ack_error, 0);
    check("rst_sda", sda, 1);
    reset = 1'b1;
    #100;
    mon_en = 1;

    // single write
    d0 = dr_seen; s0 = st_seen;
    i2c_start();
    wr_byte(8'hD4); wr_byte(8'h07); wr_byte(8'h11);
    i2c_stop(); #200;
    check("w1_strobes", dr_seen - d0, 2);
    check("w1_starts", st_seen - s0, 1);
    check("w1_data", data_out, 8'h11);

    // burst write
    d0 = dr_seen; s0 = st_seen;
    i2c_start();
    wr_byte(8'hD4); wr_byte(8'h01);
    for (int i = 1; i <= 10; i++) wr_byte(8'(i));
    i2c_stop(); #200;
    check("burst_strobes", dr_seen - d0, 11);
    check("burst_starts", st_seen - s0, 1);
    check("burst_data", data_out, 8'h0A);

    // address mismatch
    d0 = dr_seen; l0 = slave_low;
    i2c_start();
    wr_byte(8'hA0); wr_byte(8'h55);
    i2c_stop(); #200;
    check("mm_strobes", dr_seen - d0, 0);
    check("mm_sda_low", slave_low - l0, 0);
    check("mm_data", data_out, 8'h0A);

    // read with master NACK
    a0 = ae_seen;
    data_in = 8'hA5; rd_exp = 8'hA5;
    i2c_start();
    wr_byte(8'hD5);
    rd_byte(1'b1, 8'h00);
    #100;
    check("rd_released", sda, 1);
    i2c_stop(); #200;
    check("rd_ack_error", ae_seen - a0, 1);

    // repeated start
    d0 = dr_seen; s0 = st_seen;
    i2c_start();
    wr_byte(8'hD4); wr_byte(8'h03);
    i2c_start();
    wr_byte(8'hD4); wr_byte(8'h0B); wr_byte(8'h0C);
    i2c_stop(); #200;
    check("rs_strobes", dr_seen - d0, 3);
    check("rs_starts", st_seen - s0, 2);
    check("rs_data", data_out, 8'h0C);

    // reset mid-byte
    i2c_start();
    wr_byte(8'hD4); wr_byte(8'h22);
    for (int i = 0; i < 4; i++) clk_bit(1'(i & 1), smp);
    check("mid_queue", exp_q.size(), 0);
    #30 model_last = 8'h00; reset = 1'b0;
    #20;
    check("mid_data_out", data_out, 0);
    check("mid_data_ready", data_ready, 0);
    check("mid_start", start, 0);
    check("mid_ack_error", ack_error, 0);
    check("mid_sda", sda, 1);
    scl = 1'b1; m_sda = 1'b1;
    addr_phase = 0; mode = 0;
    #100 reset = 1'b1;
    #100;
    d0 = dr_seen;
    i2c_start();
    wr_byte(8'hD4); wr_byte(8'h33); wr_byte(8'h44);
    i2c_stop(); #200;
    check("post_rst_strobes", dr_seen - d0, 2);
    check("post_rst_data", data_out, 8'h44);

    // randomized transactions
    for (int k = 0; k < 30; k++) begin
      int sel, n;
      sel = $urandom_range(0, 3);
      n = $urandom_range(1, 4);
      if (sel == 0) begin
        ra = 7'($urandom);
        if (ra == 7'h6A) ra = 7'h6B;
        i2c_start();
        wr_byte({ra, 1'($urandom)});
        wr_byte(8'($urandom));
        i2c_stop();
      end else if (sel == 1) begin
        data_in = 8'($urandom); rd_exp = data_in;
        i2c_start();
        wr_byte(8'hD5);
        for (int j = 0; j < n; j++)
          rd_byte(1'(j == n - 1), 8'($urandom));
        i2c_stop();
      end else begin
        i2c_start();
        wr_byte(8'hD4);
        for (int j = 0; j < n; j++) wr_byte(8'($urandom));
        i2c_stop();
      end
      #100;
    end
    #200;

    check("final_queue", exp_q.size(), 0);
    check("final_ack_error", ae_seen, ae_exp);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
